// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU front end: bus widths, the fetch
// state encoding and the instruction field positions used by decode.
package mini_cpu_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;

   // Instruction word layout
   localparam int IDEN_MSB   = 13;
   localparam int IDEN_LSB   = 12;
   localparam int OPCODE_MSB = 11;
   localparam int OPCODE_LSB = 8;
   localparam int ADDR_MSB   = 7;
   localparam int ADDR_LSB   = 0;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_REQ  = 2'd1,
      FETCH_HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads one word at a time over a
// level request/ack bus, and hands the word to decode through MBR.
//
// state | meaning
// IDLE  | not fetching, MBR not valid, waiting for RUN
// REQ   | MEM_RD high at MEM_ADDR=PC until MEM_ACK
// HOLD  | MBR valid, waiting for decode to take it
module fetch_unit
   import mini_cpu_pkg::*;
#(
   parameter int                ADDR_W   = mini_cpu_pkg::ADDR_W,
   parameter int                DATA_W   = mini_cpu_pkg::DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              RUN,
   output logic              MEM_RD,
   output logic [ADDR_W-1:0] MEM_ADDR,
   input  logic              MEM_ACK,
   input  logic [DATA_W-1:0] MEM_DATA,
   output logic [DATA_W-1:0] MBR,
   output logic              MBR_VALID,
   input  logic              DEC_READY,
   input  logic              PC_LOAD,
   input  logic [ADDR_W-1:0] PC_IN,
   output logic [ADDR_W-1:0] PC
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] mbr_q, mbr_d;

   // Next-state logic; a redirect overrides everything, including a same-cycle ack
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      mbr_d   = mbr_q;
      unique case (state_q)
         FETCH_IDLE: begin
            if (RUN) state_d = FETCH_REQ;
         end
         FETCH_REQ: begin
            // RUN is not consulted here: a started fetch always completes
            if (MEM_ACK) begin
               mbr_d   = MEM_DATA;
               pc_d    = pc_q + ADDR_W'(1);
               state_d = FETCH_HOLD;
            end
         end
         FETCH_HOLD: begin
            if (DEC_READY) state_d = RUN ? FETCH_REQ : FETCH_IDLE;
         end
         default: state_d = FETCH_IDLE;
      endcase
      if (PC_LOAD) begin
         pc_d    = PC_IN;
         mbr_d   = mbr_q;
         state_d = RUN ? FETCH_REQ : FETCH_IDLE;
      end
   end

   // State, PC and MBR registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= FETCH_IDLE;
         pc_q    <= RESET_PC;
         mbr_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         mbr_q   <= mbr_d;
      end
   end

   // Outputs are pure decodes of registered state
   always_comb begin
      MEM_RD    = (state_q == FETCH_REQ);
      MBR_VALID = (state_q == FETCH_HOLD);
      MEM_ADDR  = pc_q;
      PC        = pc_q;
      MBR       = mbr_q;
   end

endmodule
